sd_ctrl_fsm: RTL
================

// Module: sd_ctrl_fsm
// PURPOSE
//  Second-generation SD bus controller FSM for the GhostSD OTP datapath.
//  Initialises the card, switches the bus width, then runs read-OTP-write over a block range set per run.
//  Adds bounded CRC retries, a per-state watchdog, block count, fail codes, configurable bus width.
//  Sits between the top-level start/status logic and the sd_cmd / sd_data engines.
// PARAMETERS
//  ADDR_W     23     block address width; oarg[31:9] carries the block address
//  MAX_RETRY  3      CRC-failed transfers allowed per block before failure (1..15)
//  TO_CYCLES  65535  watchdog limit, in iclk cycles, spent in one non-IDLE state
//  BUS4       1      1: ACMD6 selects 4-bit bus (arg 32'h2); 0: 1-bit bus (arg 32'h0)
//  INIT_TRIES 1000   CMD55/ACMD41 busy-poll limit; used only with SD_ACMD41_POLL_EN
// PORTS
//  iclk          in   1       clock
//  irst_n        in   1       asynchronous, active-low reset
//  istart        in   1       start a run; accepted only in IDLE
//  iblk_count    in   ADDR_W  blocks to process; sampled with istart; 0 = 2**ADDR_W
//  icmd_done     in   1       command engine finished; iresp valid
//  iresp         in   32      card response payload
//  idata_done    in   1       data engine finished a block
//  idata_crc_fail in  1       qualifies idata_done: CRC error or bad CRC status token
//  iotp_ready    in   1       OTP generator holds a fresh pad
//  osel_clk      out  1       0: identification clock; 1: transfer clock
//  ogen_otp      out  1       high while in READ
//  onew_otp      out  1       high while in IDLE
//  ostart_cmd    out  1       one-cycle pulse: issue command oindex with oarg
//  oindex        out  6       state code; command states coded with their SD command index
//  oarg          out  32      command argument (combinational from state)
//  ostart_d      out  1       one-cycle pulse: arm data engine
//  obusy         out  1       high whenever state != IDLE
//  osuccess      out  1       sticky run pass
//  ofail         out  1       sticky run fail
//  ofail_code    out  3       0 none, 1 no APP_CMD, 2 ACMD41 reject, 3 ACMD6 bad state, 4 CRC retries exhausted, 5 timeout
//  oblk_done     out  ADDR_W  blocks completed this run
// BEHAVIOUR
//  Reset: state IDLE. osel_clk, ostart_cmd, ostart_d, osuccess, ofail = 0. ofail_code = 0; oblk_done = 0. Address, RCA, retry, watchdog = 0.
//  State codes: IDLE 0, CMD2 2, CMD3 3, ACMD6 6, CMD7 7, CMD15 15, CMD17 17, READ 19, WRITE 20, CMD24 24, ACMD41 41, CMD55 55.
//  IDLE + istart -> CMD55; latch count; clear osuccess, ofail, ofail_code, oblk_done, addr, retry. istart outside IDLE is ignored.
//  CMD55 done: iresp[5] = 0 -> fail code 1. Otherwise -> ACMD41 if !osel_clk, else -> ACMD6.
//  ACMD41 done: iresp[31] & (iresp[21] | iresp[20]) -> CMD2. Otherwise -> fail code 2 (see CONFIGURATION).
//  Fixed chain: CMD2 -> CMD3; CMD3 -> CMD7 (latch RCA = iresp[31:16]); CMD7 -> CMD55.
//  ACMD6 done: iresp[12:9] == 4 -> CMD17. Otherwise -> fail code 3.
//  CMD17 done: iresp[31] (out of range) -> CMD15. Otherwise -> READ.
//  CMD24 done -> WRITE.
//  CMD15 done -> IDLE; set osuccess.
//  READ, idata_done with CRC fail: retry+1; if the new value equals MAX_RETRY -> fail code 4, else -> CMD17.
//  READ, idata_done with good CRC: set rd_ok. While rd_ok & iotp_ready -> CMD24 and clear retry. Watchdog frozen while rd_ok.
//  WRITE, idata_done with CRC fail: same retry rule, but re-enters CMD24.
//  WRITE, idata_done good: addr+1, oblk_done+1, retry = 0; new oblk_done == count -> CMD15, else -> CMD17.
//  Any failure: -> IDLE; set ofail; write ofail_code once. First failure wins.
//  Watchdog: cleared on every state change; reaching TO_CYCLES in a non-IDLE state -> fail code 5.
//  Same-cycle priority: idata_done > icmd_done > watchdog.
//  osel_clk: set on entry to CMD7; cleared on entry to IDLE.
//  ostart_cmd: registered; high the first cycle of every command state, including re-entry on retry.
//  ostart_d: registered; high the first cycle of every CMD17 and WRITE entry.
//  oarg:
//   CMD55 = {rca or 16'h0 while !osel_clk, 16'hFFFF}
//   ACMD41 = 32'h8030_0000
//   CMD7, CMD15 = {rca, 16'hFFFF}
//   ACMD6 = BUS4 ? 32'h2 : 32'h0
//   CMD17, CMD24 = {addr, 9'h0}
//   all other states = 32'hFFFF_FFFF
//  Address arithmetic wraps modulo 2**ADDR_W. Reset mid-run aborts at once; no status flag is set.
// CONFIGURATION
//  SD_ACMD41_POLL_EN defined:
//   - An ACMD41 response with iresp[31] = 0 (card busy) loops back to CMD55.
//   - Up to INIT_TRIES attempts are allowed; the attempt after that fails with code 2.
//   - A response with iresp[31] = 1 but no voltage bit set fails with code 2 immediately.
//  SD_ACMD41_POLL_EN undefined: any rejected ACMD41 fails with code 2 at once. No poll counter is synthesised.
// TESTING
//  Nominal, count = 2 -> command sequence 55,41,2,3,7,55,6,17,24,17,24,15; then osuccess = 1 and oblk_done = 2.
//  READ CRC fail twice, MAX_RETRY = 3 -> CMD17 issued 3 times at one address; run completes.
//  READ CRC fail three times -> IDLE; ofail = 1, ofail_code = 4, oblk_done = 0.
//  No icmd_done after CMD2 for 65535 cycles -> ofail_code = 5; osel_clk = 0.
//  idata_done in READ with iotp_ready low for 100k cycles, then raised -> no timeout; CMD24 pulse follows.
//  With the macro, 3 busy ACMD41 responses, then ready -> 4 CMD55/ACMD41 pairs, then CMD2. Without the macro, the first busy response gives ofail_code = 2.

Source files
------------

// File: rtl/sd_ctrl_fsm_if.sv
// Handshake/status bundle between the SD controller FSM and its start logic / cmd / data engines.
interface sd_ctrl_fsm_if #(
  parameter int ADDR_W = 23
);
  logic              istart;
  logic [ADDR_W-1:0] iblk_count;
  logic              icmd_done;
  logic [31:0]       iresp;
  logic              idata_done;
  logic              idata_crc_fail;
  logic              iotp_ready;
  logic              osel_clk;
  logic              ogen_otp;
  logic              onew_otp;
  logic              ostart_cmd;
  logic [5:0]        oindex;
  logic [31:0]       oarg;
  logic              ostart_d;
  logic              obusy;
  logic              osuccess;
  logic              ofail;
  logic [2:0]        ofail_code;
  logic [ADDR_W-1:0] oblk_done;

  modport slave (
    input  istart, iblk_count, icmd_done, iresp, idata_done, idata_crc_fail, iotp_ready,
    output osel_clk, ogen_otp, onew_otp, ostart_cmd, oindex, oarg, ostart_d,
           obusy, osuccess, ofail, ofail_code, oblk_done
  );

  modport master (
    output istart, iblk_count, icmd_done, iresp, idata_done, idata_crc_fail, iotp_ready,
    input  osel_clk, ogen_otp, onew_otp, ostart_cmd, oindex, oarg, ostart_d,
           obusy, osuccess, ofail, ofail_code, oblk_done
  );
endinterface

// File: rtl/sd_ctrl_fsm.sv
// SD controller FSM: card init, bus-width switch, then read-OTP-write over a block range with retries and watchdog.
// Optional ACMD41 busy polling is enabled by defining SD_ACMD41_POLL_EN.
module sd_ctrl_fsm #(
  parameter int ADDR_W     = 23,
  parameter int MAX_RETRY  = 3,
  parameter int TO_CYCLES  = 65535,
  parameter int BUS4       = 1,
  parameter int INIT_TRIES = 1000
) (
  input logic         iclk,
  input logic         irst_n,
  sd_ctrl_fsm_if.slave bus
);

  localparam int WD_W = $clog2(TO_CYCLES + 1);

  typedef enum logic [5:0] {
    S_IDLE   = 6'd0,
    S_CMD2   = 6'd2,
    S_CMD3   = 6'd3,
    S_ACMD6  = 6'd6,
    S_CMD7   = 6'd7,
    S_CMD15  = 6'd15,
    S_CMD17  = 6'd17,
    S_READ   = 6'd19,
    S_WRITE  = 6'd20,
    S_CMD24  = 6'd24,
    S_ACMD41 = 6'd41,
    S_CMD55  = 6'd55
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_cnt, r_addr, r_blk_done;
  logic [15:0]       r_rca;
  logic [3:0]        r_retry, w_retry_plus;
  logic [WD_W-1:0]   r_wdog;
  logic              r_rd_ok, r_sel_clk, r_start_cmd, r_start_d;
  logic              r_success, r_fail;
  logic [2:0]        r_fail_code;

  logic        w_fail, w_run, w_succ, w_rca_ld, w_rd_ok_set;
  logic        w_retry_inc, w_retry_clr, w_blk_inc, w_change, w_is_cmd;
  logic [2:0]  w_code;
  logic [31:0] w_addr_arg;
  logic [ADDR_W-1:0] w_blk_plus;

`ifdef SD_ACMD41_POLL_EN
  localparam int PL_W = $clog2(INIT_TRIES + 1);
  logic [PL_W-1:0] r_poll;
  logic            w_poll_inc;
`endif

  assign w_retry_plus = r_retry + 4'd1;
  assign w_blk_plus   = r_blk_done + 1'b1;

  always_comb begin
    w_next      = r_state;
    w_fail      = 1'b0;
    w_code      = 3'd0;
    w_run       = 1'b0;
    w_succ      = 1'b0;
    w_rca_ld    = 1'b0;
    w_rd_ok_set = 1'b0;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    w_blk_inc   = 1'b0;
`ifdef SD_ACMD41_POLL_EN
    w_poll_inc  = 1'b0;
`endif
    case (r_state)
      S_IDLE: if (bus.istart) begin
        w_next = S_CMD55;
        w_run  = 1'b1;
      end
      S_CMD55: if (bus.icmd_done) begin
        if (!bus.iresp[5]) begin
          w_fail = 1'b1; w_code = 3'd1;
        end else begin
          w_next = r_sel_clk ? S_ACMD6 : S_ACMD41;
        end
      end
      S_ACMD41: if (bus.icmd_done) begin
        if (bus.iresp[31] && (bus.iresp[21] || bus.iresp[20])) begin
          w_next = S_CMD2;
`ifdef SD_ACMD41_POLL_EN
        end else if (!bus.iresp[31] && (r_poll != PL_W'(INIT_TRIES - 1))) begin
          w_next     = S_CMD55;
          w_poll_inc = 1'b1;
`endif
        end else begin
          w_fail = 1'b1; w_code = 3'd2;
        end
      end
      S_CMD2: if (bus.icmd_done) w_next = S_CMD3;
      S_CMD3: if (bus.icmd_done) begin
        w_next   = S_CMD7;
        w_rca_ld = 1'b1;
      end
      S_CMD7: if (bus.icmd_done) w_next = S_CMD55;
      S_ACMD6: if (bus.icmd_done) begin
        if (bus.iresp[12:9] == 4'd4) w_next = S_CMD17;
        else begin
          w_fail = 1'b1; w_code = 3'd3;
        end
      end
      S_CMD17: if (bus.icmd_done) w_next = bus.iresp[31] ? S_CMD15 : S_READ;
      S_CMD24: if (bus.icmd_done) w_next = S_WRITE;
      S_CMD15: if (bus.icmd_done) begin
        w_next = S_IDLE;
        w_succ = 1'b1;
      end
      S_READ: begin
        if (bus.idata_done) begin
          if (bus.idata_crc_fail) begin
            w_retry_inc = 1'b1;
            if (w_retry_plus == 4'(MAX_RETRY)) begin
              w_fail = 1'b1; w_code = 3'd4;
            end else begin
              w_next = S_CMD17;
            end
          end else begin
            w_rd_ok_set = 1'b1;
          end
        end else if (r_rd_ok && bus.iotp_ready) begin
          w_next      = S_CMD24;
          w_retry_clr = 1'b1;
        end
      end
      S_WRITE: if (bus.idata_done) begin
        if (bus.idata_crc_fail) begin
          w_retry_inc = 1'b1;
          if (w_retry_plus == 4'(MAX_RETRY)) begin
            w_fail = 1'b1; w_code = 3'd4;
          end else begin
            w_next = S_CMD24;
          end
        end else begin
          w_blk_inc   = 1'b1;
          w_retry_clr = 1'b1;
          w_next      = (w_blk_plus == r_cnt) ? S_CMD15 : S_CMD17;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Watchdog only fires when no data/cmd event was consumed this cycle
    if (r_state != S_IDLE && w_next == r_state && !w_fail && !w_rd_ok_set && !r_rd_ok
        && r_wdog == WD_W'(TO_CYCLES - 1)) begin
      w_fail = 1'b1; w_code = 3'd5;
    end
    if (w_fail) w_next = S_IDLE;
  end

  assign w_change = (w_next != r_state);
  assign w_is_cmd = (w_next != S_IDLE) && (w_next != S_READ) && (w_next != S_WRITE);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_blk_done  <= '0;
      r_rca       <= '0;
      r_retry     <= '0;
      r_wdog      <= '0;
      r_rd_ok     <= 1'b0;
      r_sel_clk   <= 1'b0;
      r_start_cmd <= 1'b0;
      r_start_d   <= 1'b0;
      r_success   <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_code <= 3'd0;
    end else begin
      r_state     <= w_next;
      r_start_cmd <= w_change && w_is_cmd;
      r_start_d   <= w_change && (w_next == S_CMD17 || w_next == S_WRITE);
      if (w_change && w_next == S_CMD7) r_sel_clk <= 1'b1;
      else if (w_change && w_next == S_IDLE) r_sel_clk <= 1'b0;
      if (w_change || r_state == S_IDLE) r_wdog <= '0;
      else if (!r_rd_ok) r_wdog <= r_wdog + 1'b1;
      if (w_change) r_rd_ok <= 1'b0;
      else if (w_rd_ok_set) r_rd_ok <= 1'b1;
      if (w_run || w_retry_clr) r_retry <= '0;
      else if (w_retry_inc) r_retry <= w_retry_plus;
      if (w_rca_ld) r_rca <= bus.iresp[31:16];
      if (w_run) begin
        r_cnt       <= bus.iblk_count;
        r_addr      <= '0;
        r_blk_done  <= '0;
        r_success   <= 1'b0;
        r_fail      <= 1'b0;
        r_fail_code <= 3'd0;
      end else begin
        if (w_blk_inc) begin
          r_addr     <= r_addr + 1'b1;
          r_blk_done <= w_blk_plus;
        end
        if (w_succ) r_success <= 1'b1;
        if (w_fail) begin
          r_fail <= 1'b1;
          if (!r_fail) r_fail_code <= w_code;
        end
      end
    end
  end

`ifdef SD_ACMD41_POLL_EN
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n)         r_poll <= '0;
    else if (w_run)      r_poll <= '0;
    else if (w_poll_inc) r_poll <= r_poll + 1'b1;
  end
`endif

  always_comb begin
    w_addr_arg = '0;
    w_addr_arg[ADDR_W+8:9] = r_addr;
  end

  always_comb begin
    case (r_state)
      S_CMD55:          bus.oarg = {(r_sel_clk ? r_rca : 16'h0), 16'hFFFF};
      S_ACMD41:         bus.oarg = 32'h8030_0000;
      S_CMD7, S_CMD15:  bus.oarg = {r_rca, 16'hFFFF};
      S_ACMD6:          bus.oarg = (BUS4 != 0) ? 32'h0000_0002 : 32'h0000_0000;
      S_CMD17, S_CMD24: bus.oarg = w_addr_arg;
      default:          bus.oarg = 32'hFFFF_FFFF;
    endcase
  end

  assign bus.oindex     = r_state;
  assign bus.osel_clk   = r_sel_clk;
  assign bus.ogen_otp   = (r_state == S_READ);
  assign bus.onew_otp   = (r_state == S_IDLE);
  assign bus.obusy      = (r_state != S_IDLE);
  assign bus.ostart_cmd = r_start_cmd;
  assign bus.ostart_d   = r_start_d;
  assign bus.osuccess   = r_success;
  assign bus.ofail      = r_fail;
  assign bus.ofail_code = r_fail_code;
  assign bus.oblk_done  = r_blk_done;

endmodule
